ofifo: RTL and testbench
========================

OFIFO -- requirements
Module: ofifo

Interface
REQ-001 Parameter col, default 8: number of columns (FIFO lanes), matching the MAC array width.
REQ-002 Parameter psum_bw, default 16: width of one partial-sum word per column.
REQ-003 Parameter depth, default 64: entries per column lane; power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in  input  psum_bw*col  psums from the array's south edge; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 wr  input  col  per-column write strobes, driven by the array's valid vector.
REQ-008 rd  input  1  pop request for one full row (all columns together).
REQ-009 out  output  psum_bw*col  head entry of every lane, same column packing as in.
REQ-010 o_valid  output  1  every lane is non-empty, so a complete row is available.
REQ-011 o_full  output  1  at least one lane is full.
REQ-012 o_ready  output  1  no lane is full (the inverse of o_full).

Function
REQ-013 Each column lane SHALL be an independent FIFO of depth entries; the lane for column c is written when wr[c]=1 at a rising edge.
REQ-014 Lanes fill skewed in time, because the array emits columns on different cycles. Words within a lane SHALL stay in write order.
REQ-015 o_valid SHALL be 1 in exactly the cycles where the count of every lane is at least 1.
REQ-016 rd=1 with o_valid=1 SHALL pop one entry from every lane at the same edge. rd=1 with o_valid=0 SHALL be ignored, and no lane changes.
REQ-017 out SHALL be first-word-fall-through: it shows the head of each lane combinationally from storage, and the new head appears the cycle after a pop.
REQ-018 When a lane is empty, its out slice SHALL hold the last stored or reset value of its head slot; its content is don't-care while o_valid=0.
REQ-019 A write to a full lane SHALL be dropped unless that lane is popped at the same edge, in which case the write SHALL be accepted and the count stays at depth.
REQ-020 A simultaneous write and pop on a non-empty lane SHALL leave its count unchanged and keep ordering.
REQ-021 Pointers SHALL be log2(depth)+1 bits wide, with the MSB used as a wrap bit. Empty is ptr_w==ptr_r; full is equal low bits with differing MSB. Wrap-around SHALL be seamless.
REQ-022 Write-to-read latency SHALL be one edge: a word written at edge N is visible on out, with o_valid reflecting it, after edge N.

Reset
REQ-023 reset=0 SHALL asynchronously clear all read and write pointers.
REQ-024 During reset: o_valid=0, o_full=0, o_ready=1. Storage is not cleared, and out is don't-care.
REQ-025 Reset asserted mid-operation SHALL discard all contents immediately. The first edge after release SHALL accept writes normally.

Configuration
REQ-026 Macro OFIFO_OVF_EN controls the overflow flag.
- Defined: the block adds output o_overflow (1 bit, sticky). It is set on any dropped write (REQ-019) and cleared only by reset.
- Undefined: the port is absent and dropped writes are silent.

Structure
REQ-027 A shared package ofifo_pkg SHALL hold the default constants COL, PSUM_BW and DEPTH, plus a pointer-width constant computed as clog2 of DEPTH plus 1.
REQ-028 A single-lane sub-module fifo_col (width psum_bw, depth depth) SHALL be instantiated col times in a generate loop.
REQ-029 fifo_col SHALL provide the per-lane push, pop, empty, full and head signals. The top level SHALL AND the per-lane non-empty flags into o_valid, OR the full flags into o_full, and broadcast the qualified pop.

Verification
REQ-030 Reset, then write 0x0001..0x0008 to all columns on one edge -> o_valid=1 the next cycle, and column c shows c+1.
REQ-031 Skewed writes (wr=8'b00000001, then 00000011, ..., then 11111111) -> o_valid rises only after the edge where column 7 is first written; out then holds the first word of each lane.
REQ-032 Fill column 0 with 64 words -> o_full=1 and o_ready=0; a 65th write is dropped; with OFIFO_OVF_EN, o_overflow=1.
REQ-033 Full lane plus simultaneous write and rd -> count stays 64, and the popped and written words keep ordering across pointer wrap.
REQ-034 rd=1 while column 3 is empty -> no pointer moves in any lane, and out is unchanged.
REQ-035 Pull reset low mid-stream with 10 rows stored -> o_valid=0 immediately, without waiting for an edge; after release, a new write appears alone at the head.

Source files
------------

// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared constants for the output FIFO.
//   COL     - default number of column lanes (MAC array width)
//   PSUM_BW - default partial-sum word width per column
//   DEPTH   - default entries per lane (power of two, >= 2)
//   PTR_W   - pointer width: address bits plus one wrap bit
package ofifo_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 64;

  // One extra MSB beyond the address bits lets full and empty be told
  // apart when the low pointer bits are equal.
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int PTR_W = ptr_width(DEPTH);

endpackage

// File: rtl/ofifo_if.sv
// ofifo_if: bus between the MAC array's south edge and the output FIFO.
//   in      - packed psums, column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr      - per-column write strobes
//   rd      - pop request for one full row
//   out     - head entry of every lane, same packing as in
//   o_valid - every lane non-empty (a complete row is presented)
//   o_full  - at least one lane is full
//   o_ready - no lane is full
//
// Handshake: a row transfers out on a rising edge where rd=1 and
// o_valid=1; rd with o_valid=0 is ignored. A column word transfers in
// on an edge where wr[c]=1 and that lane is not full, or is popped on
// the same edge. o_ready is advisory: it reports that every lane can
// take a word, it does not gate individual lane writes.
interface ofifo_if
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW
);

  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready
  );

endinterface

// File: rtl/ofifo_fifo_col.sv
// fifo_col: one column lane of the output FIFO, first-word-fall-through.
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset, clears pointers only
//   push_i  - write request
//   pop_i   - pop request (ignored when empty)
//   din_i   - write data
//   dout_o  - head of lane, read combinationally from storage
//   empty_o - lane holds no entries
//   full_o  - lane holds depth entries
//   drop_o  - a write was refused on this edge (full, not popped)
module fifo_col
  import ofifo_pkg::*;
#(
  parameter int width = PSUM_BW,
  parameter int depth = DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] din_i,
  output logic [width-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int AW = $clog2(depth);
  localparam int PW = ptr_width(depth);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [width-1:0] mem_q [depth];
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A full lane still accepts a write when it is popped on the same
  // edge: the freed slot is the one the write pointer targets.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  // When empty this shows whatever the head slot last held.
  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ofifo.sv
// ofifo: output FIFO behind the MAC array. col independent lanes fill
// skewed in time and are drained one full row at a time.
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset (pointers cleared)
//   bus        - ofifo_if.slave: in, wr, rd, out, o_valid, o_full, o_ready
//   o_overflow - sticky dropped-write flag, present only when the
//                OFIFO_OVF_EN macro is defined; cleared only by reset
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  ofifo_if.slave bus
`ifdef OFIFO_OVF_EN
  ,
  output logic  o_overflow
`endif
);

  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         lane_drop;
  logic [psum_bw*col-1:0] head;
  logic                   row_valid;
  logic                   pop;

  assign row_valid = &(~lane_empty);
  // The pop is qualified once here and broadcast so every lane moves
  // together; an unqualified rd leaves all lanes untouched.
  assign pop       = bus.rd & row_valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    fifo_col #(
      .width (psum_bw),
      .depth (depth)
    ) u_lane (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (bus.wr[c]),
      .pop_i   (pop),
      .din_i   (bus.in[psum_bw*c +: psum_bw]),
      .dout_o  (head[psum_bw*c +: psum_bw]),
      .empty_o (lane_empty[c]),
      .full_o  (lane_full[c]),
      .drop_o  (lane_drop[c])
    );
  end

  assign bus.out     = head;
  assign bus.o_valid = row_valid;
  assign bus.o_full  = |lane_full;
  assign bus.o_ready = ~(|lane_full);

`ifdef OFIFO_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (|lane_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = ^lane_drop;
`endif

endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo: self-checking bench for ofifo. A per-lane queue model tracks
// expected contents; outputs are checked on the falling edge.
module tb_ofifo;
  import ofifo_pkg::*;

  localparam int COLS = 8;
  localparam int W    = 16;
  localparam int D    = 64;
  localparam int BW   = COLS * W;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofifo_if #(.col(COLS), .psum_bw(W)) bus ();

`ifdef OFIFO_OVF_EN
  logic ovf;
`endif

  ofifo #(.col(COLS), .psum_bw(W), .depth(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef OFIFO_OVF_EN
    ,
    .o_overflow (ovf)
`endif
  );

  // scoreboard: one expected queue per lane
  logic [W-1:0] exp_q [COLS][$];
  logic         m_ovf;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) exp_q[c].delete();
    m_ovf = 1'b0;
  endtask

  // One rising edge of the reference: a row pops only if every lane
  // holds data; a write lands unless its lane was full and not popped.
  task automatic model_edge(input logic [COLS-1:0] w, input logic [BW-1:0] d,
                            input logic r);
    bit all_ne = 1'b1;
    bit popped;
    bit was_full;
    for (int c = 0; c < COLS; c++) if (exp_q[c].size() == 0) all_ne = 1'b0;
    popped = r && all_ne;
    for (int c = 0; c < COLS; c++) begin
      was_full = (exp_q[c].size() == D);
      if (popped) void'(exp_q[c].pop_front());
      if (w[c]) begin
        if (!was_full || popped) exp_q[c].push_back(d[c*W +: W]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [BW-1:0] e = '0;
    logic [BW-1:0] m = '0;
    bit v = 1'b1;
    bit f = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (exp_q[c].size() > 0) begin
        e[c*W +: W] = exp_q[c][0];
        m[c*W +: W] = '1;
      end else begin
        v = 1'b0;
      end
      if (exp_q[c].size() == D) f = 1'b1;
    end
    chk("o_valid", BW'(bus.o_valid), BW'(v));
    chk("o_full",  BW'(bus.o_full),  BW'(f));
    chk("o_ready", BW'(bus.o_ready), BW'(!f));
    chk("out_head", bus.out & m, e);
`ifdef OFIFO_OVF_EN
    chk("o_overflow", BW'(ovf), BW'(m_ovf));
`endif
  endtask

  // driver: present inputs at negedge, model the rising edge, check at next negedge
  task automatic step(input logic [COLS-1:0] w, input logic [BW-1:0] d,
                      input logic r);
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    @(posedge clk);
    model_edge(w, d, r);
    @(negedge clk);
    bus.wr = '0;
    bus.rd = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", BW'(bus.o_valid), BW'(0));
    chk("rst_full",  BW'(bus.o_full),  BW'(0));
    chk("rst_ready", BW'(bus.o_ready), BW'(1));
`ifdef OFIFO_OVF_EN
    chk("rst_ovf", BW'(ovf), BW'(0));
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [BW-1:0] rnd_row();
    logic [BW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic bit model_valid();
    for (int c = 0; c < COLS; c++) if (exp_q[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [BW-1:0]   row;
    logic [COLS-1:0] w;
    bus.in = '0;
    bus.wr = '0;
    bus.rd = 1'b0;
    m_ovf  = 1'b0;
    do_reset();

    // one row 1..8 written on a single edge
    row = '0;
    for (int c = 0; c < COLS; c++) row[c*W +: W] = W'(c + 1);
    step('1, row, 1'b0);
    chk("row_1to8", bus.out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("row_valid", BW'(bus.o_valid), BW'(1));
    step('0, '0, 1'b1);

    // skewed fill: one more column each edge
    for (int k = 0; k < COLS; k++) begin
      w = COLS'((1 << (k + 1)) - 1);
      step(w, rnd_row(), 1'b0);
      chk("skew_valid", BW'(bus.o_valid), BW'(k == COLS - 1));
    end
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);

    // fill lane 0, then one dropped write
    do_reset();
    for (int i = 0; i < D; i++) step(8'h01, rnd_row(), 1'b0);
    chk("lane0_full", BW'(bus.o_full), BW'(1));
    step(8'h01, rnd_row(), 1'b0);
    chk("lane0_ready", BW'(bus.o_ready), BW'(0));

    // full lane with simultaneous write and pop, enough to wrap pointers
    step(8'hFE, rnd_row(), 1'b0);
    for (int i = 0; i < D + 10; i++) step('1, rnd_row(), 1'b1);
    chk("wrap_full", BW'(bus.o_full), BW'(1));

    // rd while column 3 is empty is ignored
    do_reset();
    for (int i = 0; i < 3; i++) step(8'hF7, rnd_row(), 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step(8'h08, rnd_row(), 1'b0);
    step('0, '0, 1'b1);

    // asynchronous reset mid-stream with 10 rows stored
    do_reset();
    for (int i = 0; i < 10; i++) step('1, rnd_row(), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", BW'(bus.o_valid), BW'(0));
    chk("async_ready", BW'(bus.o_ready), BW'(1));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    row = rnd_row();
    step('1, row, 1'b0);
    chk("post_rst_head", bus.out, row);

    // random traffic: write-heavy phase then drain-heavy phase
    do_reset();
    for (int i = 0; i < 600; i++) begin
      w = COLS'($urandom);
      if (i < 300) step(w, rnd_row(), $urandom_range(0, 3) == 0);
      else         step(w & COLS'($urandom), rnd_row(), $urandom_range(0, 3) != 0);
    end
    while (model_valid()) step('0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
